dot_score_tracker: RTL
======================

// Module: dot_score_tracker
// PURPOSE
//  Downstream of the per-dot collision instances. Collects their sticky collide flags and credits each dot
//  exactly once per level. Keeps a saturating BCD score, a remaining-dot count and a level-clear handshake.
//  Publishes a frame-stable score copy for the HUD renderer. Sits between the dot array and the HUD/game FSM.
// PARAMETERS
//  N_DOTS      16  number of dot instances on the maze (2..255)
//  DOT_POINTS  5   points per dot, single BCD digit (1..9)
//  DIGITS      4   BCD score digits
// PORTS
//  Clk            in   1           system clock
//  Reset          in   1           synchronous, active-high reset
//  frame_start    in   1           1-cycle pulse at start of vertical blank
//  dot_collide    in   N_DOTS      sticky collide flag per dot instance
//  level_restart  in   1           1-cycle request from game FSM to start next level
//  dot_reset      out  1           1-cycle pulse; drives Reset of all dot instances
//  dot_event      out  1           1-cycle pulse per credited dot (sound/FX)
//  dots_left      out  8           dots not yet credited this level
//  level_clear    out  1           high while waiting for level_restart
//  level_num      out  8           current level, starts at 1
//  score_disp     out  4*DIGITS    BCD score, updated only on frame_start
// BEHAVIOUR
//  Reset values
//   - dot_reset=0, dot_event=0, dots_left=N_DOTS, level_clear=0, level_num=1, score_disp=0.
//   - Internal score=0; prev, pending and credited masks = 0; state=PLAY.
//  Capture
//   - new = dot_collide & ~prev & ~credited. prev <= dot_collide every cycle.
//   - pending <= (pending | new) & ~sel each cycle.
//   - Simultaneous rises on any number of dots are all captured.
//  Credit, PLAY only
//   - At most one dot credited per cycle: sel = lowest-index set bit of pending.
//   - Credit in cycle t updates all of the following at edge t+1:
//     - credited[sel] set.
//     - score += DOT_POINTS as a digit-wise BCD add with carry ripple; saturates at all-9s.
//     - dots_left decrements.
//     - dot_event = 1 for that cycle only.
//   - Latency from a collide rise to dot_event: 2 cycles plus the number of lower-index dots still pending.
//  FSM: PLAY -> CLEAR -> RESTART -> PLAY
//   - PLAY -> CLEAR on the edge at which dots_left becomes 0. level_clear=1 from that edge.
//   - CLEAR:
//     - New rises are ignored.
//     - pending is not serviced.
//     - Waits for level_restart.
//   - level_restart outside CLEAR is ignored.
//   - CLEAR -> RESTART on level_restart.
//   - RESTART lasts 1 cycle. During it:
//     - dot_reset=1.
//     - Clears prev, pending and credited.
//     - dots_left=N_DOTS.
//     - level_num += 1, wrapping 255 -> 1.
//     - level_clear=0.
//     - score is kept.
//   - RESTART -> PLAY unconditionally.
//  Display
//   - score_disp <= score on frame_start.
//   - If frame_start and a credit coincide, score_disp takes the pre-credit value.
//  Reset mid-operation
//   - Any state returns to PLAY with the reset values above. dot_reset is NOT pulsed, because dot instances share Reset.
// STRUCTURE
//  - pacman_pkg holds:
//    - typedef enum logic [1:0] {PLAY, CLEAR, RESTART} score_state_t;
//    - N_DOTS_DEFAULT and DIGIT_W = 4.
//    - Function bcd_add_digit(a, b, cin) -> {cout, sum}.
//  - Sub-module lsb_priority_enc #(N): onehot select plus valid flag; used for sel.
//  - The remaining RTL is single-clock registers plus the FSM.
// TESTING  (N_DOTS=4, DOT_POINTS=5, DIGITS=4)
//  1. Reset, then dot_collide=4'b0010 held high for 10 cycles:
//     - Exactly one dot_event, 2 cycles after the rise.
//     - dots_left=3; score=0005 at the next frame_start.
//  2. dot_collide 0 -> 4'b1011 in one cycle:
//     - dot_event on 3 consecutive cycles, in order dot0, dot1, dot3.
//     - dots_left goes 4 -> 1; score=0015.
//  3. Credit all 4 dots:
//     - level_clear=1 on the edge where dots_left=0.
//     - A later rise on dot2 gives no dot_event.
//     - level_restart gives 1 dot_reset pulse, dots_left=4, level_num=2, score=0020 kept.
//  4. Preload score 9995 (force), then credit 2 dots -> score saturates at 9999.
//  5. frame_start in the same cycle as a credit from score 0010:
//     - score_disp=0010.
//     - The next frame_start gives 0015.
//  6. Assert Reset while in CLEAR with pending bits set:
//     - All outputs return to reset values; dot_reset stays 0.
//     - level_restart before any credit is ignored.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and helpers for the maze scoring slice.
//   score_state_t  : scoring FSM states (PLAY -> CLEAR -> RESTART -> PLAY)
//   N_DOTS_DEFAULT : default number of dot instances
//   DIGIT_W        : bits per BCD digit
//   bcd_add_digit  : one-digit BCD add with carry in/out, returns {cout, sum}
package pacman_pkg;

  typedef enum logic [1:0] {PLAY, CLEAR, RESTART} score_state_t;

  localparam int unsigned N_DOTS_DEFAULT = 16;
  localparam int unsigned DIGIT_W        = 4;

  function automatic logic [DIGIT_W:0] bcd_add_digit(
    input logic [DIGIT_W-1:0] a,
    input logic [DIGIT_W-1:0] b,
    input logic               cin
  );
    logic [DIGIT_W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    if (s > 5'd9) begin
      // Low nibble minus ten wraps to the correct decimal digit for 10..19.
      return {1'b1, s[DIGIT_W-1:0] - DIGIT_W'(10)};
    end
    return {1'b0, s[DIGIT_W-1:0]};
  endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-index-first priority encoder.
//   req    in  N  request vector
//   onehot out N  only the lowest set bit of req (zero if none)
//   valid  out 1  any request present
module lsb_priority_enc #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic         valid
);

  // Two's complement isolates the lowest set bit.
  always_comb begin
    onehot = req & (~req + {{(N-1){1'b0}}, 1'b1});
    valid  = |req;
  end

endmodule

// File: rtl/dot_score_tracker.sv
// Collects sticky per-dot collide flags, credits each dot once per level,
// keeps a saturating BCD score, a remaining-dot count, the level-clear
// handshake and a frame-stable score copy for the HUD.
//   Clk, Reset     clock, synchronous active-high reset
//   frame_start    1-cycle pulse at start of vertical blank
//   dot_collide    sticky collide flag per dot instance
//   level_restart  1-cycle request from game FSM to start next level
//   dot_reset      1-cycle pulse resetting all dot instances
//   dot_event      1-cycle pulse per credited dot
//   dots_left      dots not yet credited this level
//   level_clear    high while waiting for level_restart
//   level_num      current level, starts at 1, wraps 255 -> 1
//   score_disp     BCD score, refreshed only on frame_start
module dot_score_tracker
  import pacman_pkg::*;
#(
  parameter int unsigned N_DOTS     = N_DOTS_DEFAULT,
  parameter int unsigned DOT_POINTS = 5,
  parameter int unsigned DIGITS     = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_start,
  input  logic [N_DOTS-1:0]         dot_collide,
  input  logic                      level_restart,
  output logic                      dot_reset,
  output logic                      dot_event,
  output logic [7:0]                dots_left,
  output logic                      level_clear,
  output logic [7:0]                level_num,
  output logic [DIGIT_W*DIGITS-1:0] score_disp
);

  score_state_t state, state_nxt;

  logic [N_DOTS-1:0] prev, pending, credited;
  logic [N_DOTS-1:0] new_rise, sel, take;
  logic              sel_valid, credit;

  logic [DIGIT_W*DIGITS-1:0] score, score_inc;
  logic [DIGIT_W:0]          dsum;
  logic                      carry;

  lsb_priority_enc #(.N(N_DOTS)) u_sel (
    .req    (pending),
    .onehot (sel),
    .valid  (sel_valid)
  );

  // Rises are only accepted while playing; credited dots never re-arm.
  always_comb begin
    new_rise = dot_collide & ~prev & ~credited & {N_DOTS{state == PLAY}};
    credit   = (state == PLAY) && sel_valid;
    take     = credit ? sel : '0;
  end

  // Digit-wise BCD add of DOT_POINTS; a carry out of the top digit saturates.
  always_comb begin
    score_inc = '0;
    carry     = 1'b0;
    dsum      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dsum = bcd_add_digit(score[i*DIGIT_W +: DIGIT_W],
                           (i == 0) ? DIGIT_W'(DOT_POINTS) : DIGIT_W'(0),
                           carry);
      score_inc[i*DIGIT_W +: DIGIT_W] = dsum[DIGIT_W-1:0];
      carry = dsum[DIGIT_W];
    end
    if (carry) begin
      score_inc = {DIGITS{4'd9}};
    end
  end

  always_comb begin
    state_nxt   = state;
    dot_reset   = 1'b0;
    level_clear = 1'b0;
    unique case (state)
      PLAY: begin
        if (credit && dots_left == 8'd1) state_nxt = CLEAR;
      end
      CLEAR: begin
        level_clear = 1'b1;
        if (level_restart) state_nxt = RESTART;
      end
      RESTART: begin
        dot_reset = 1'b1;
        state_nxt = PLAY;
      end
      default: state_nxt = PLAY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= PLAY;
      prev       <= '0;
      pending    <= '0;
      credited   <= '0;
      score      <= '0;
      score_disp <= '0;
      dots_left  <= 8'(N_DOTS);
      level_num  <= 8'd1;
      dot_event  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dot_event <= credit;

      // Sampled before this edge's credit lands, so a coinciding credit
      // shows up on the following frame.
      if (frame_start) score_disp <= score;

      // Counters step when entering RESTART; masks clear when leaving it.
      if (state == RESTART) begin
        prev     <= '0;
        pending  <= '0;
        credited <= '0;
      end else begin
        prev     <= dot_collide;
        pending  <= (pending | new_rise) & ~take;
        credited <= credited | take;
      end

      if (credit) begin
        score     <= score_inc;
        dots_left <= dots_left - 8'd1;
      end

      if (state == CLEAR && level_restart) begin
        dots_left <= 8'(N_DOTS);
        level_num <= (level_num == 8'd255) ? 8'd1 : level_num + 8'd1;
      end
    end
  end

endmodule
